iq_demod: RTL and testbench

IQ_DEMOD -- requirements
Module: iq_demod

---
 rtl/iq_demod.sv | 150 +++++++++++++++
 tb/tb_iq_demod.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_demod.sv
// Synchronous I/Q demodulator: correlates ADC samples against a 64-point sine/cosine
// reference over NUM_PERIODS periods. Define IQ_OFFSET_BINARY_EN for offset-binary ADC data.
module iq_demod #(
    parameter int ADC_W       = 12,
    parameter int NUM_PERIODS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_start,
    input  logic             abort,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [31:0]      iq_x,
    output logic [31:0]      iq_y,
    output logic             iq_valid,
    output logic             busy
);

    localparam int TOTAL  = 64 * NUM_PERIODS;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int PROD_W = ADC_W + 16;
    localparam int ACC_W  = 38;

    typedef enum logic [1:0] {StIdle, StAcc, StFlush, StDump} state_t;

    // Quarter-wave table: round(16383 * sin(2*pi*i/64)) for i = 0..16.
    function automatic logic signed [15:0] quarter(input logic [4:0] i);
        case (i)
            5'd0:    return 16'sd0;
            5'd1:    return 16'sd1606;
            5'd2:    return 16'sd3196;
            5'd3:    return 16'sd4756;
            5'd4:    return 16'sd6270;
            5'd5:    return 16'sd7723;
            5'd6:    return 16'sd9102;
            5'd7:    return 16'sd10393;
            5'd8:    return 16'sd11585;
            5'd9:    return 16'sd12664;
            5'd10:   return 16'sd13622;
            5'd11:   return 16'sd14449;
            5'd12:   return 16'sd15136;
            5'd13:   return 16'sd15678;
            5'd14:   return 16'sd16068;
            5'd15:   return 16'sd16304;
            5'd16:   return 16'sd16383;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [15:0] sin_lut(input logic [5:0] k);
        logic [4:0]         idx;
        logic signed [15:0] m;
        idx = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
        m   = quarter(idx);
        return k[5] ? -m : m;
    endfunction

    function automatic logic signed [15:0] cos_lut(input logic [5:0] k);
        return sin_lut(k + 6'd16);
    endfunction

    state_t                    st;
    logic [5:0]                k;
    logic [CNT_W-1:0]          cnt;
    logic signed [ADC_W-1:0]   samp;
    logic                      s1_v, s2_v;
    logic signed [ADC_W-1:0]   s1_samp;
    logic signed [15:0]        s1_cos, s1_sin;
    logic signed [PROD_W-1:0]  px, py;
    logic signed [ACC_W-1:0]   acc_x, acc_y;

    always_comb begin
`ifdef IQ_OFFSET_BINARY_EN
        samp = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
`else
        samp = adc_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= StIdle;
            k        <= '0;
            cnt      <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_samp  <= '0;
            s1_cos   <= '0;
            s1_sin   <= '0;
            px       <= '0;
            py       <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            iq_x     <= '0;
            iq_y     <= '0;
            iq_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Two-stage pipeline: table lookup, then multiply, then accumulate.
            iq_valid <= 1'b0;
            s1_v     <= 1'b0;
            s2_v     <= s1_v;
            px       <= s1_samp * s1_cos;
            py       <= s1_samp * s1_sin;
            if (s2_v) begin
                acc_x <= acc_x + {{(ACC_W-PROD_W){px[PROD_W-1]}}, px};
                acc_y <= acc_y + {{(ACC_W-PROD_W){py[PROD_W-1]}}, py};
            end
            if (abort) begin
                st    <= StIdle;
                busy  <= 1'b0;
                s1_v  <= 1'b0;
                s2_v  <= 1'b0;
                acc_x <= '0;
                acc_y <= '0;
            end else begin
                case (st)
                    StIdle: if (meas_start) begin
                        acc_x <= '0;
                        acc_y <= '0;
                        k     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        st    <= StAcc;
                    end
                    StAcc: if (adc_valid) begin
                        s1_v    <= 1'b1;
                        s1_samp <= samp;
                        s1_cos  <= cos_lut(k);
                        s1_sin  <= sin_lut(k);
                        k       <= k + 6'd1;
                        cnt     <= cnt + 1'b1;
                        if (cnt == CNT_W'(TOTAL - 1)) st <= StFlush;
                    end
                    // Last product is being accumulated on this edge.
                    StFlush: if (s2_v && !s1_v) st <= StDump;
                    StDump: begin
                        iq_x     <= acc_x[ACC_W-1:6];
                        iq_y     <= acc_y[ACC_W-1:6];
                        iq_valid <= 1'b1;
                        busy     <= 1'b0;
                        st       <= StIdle;
                    end
                    default: st <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iq_demod.sv
// Self-checking bench for iq_demod: table vectors, randomized runs against a real-valued
// correlation model, plus abort, reset and back-to-back sequences.
module tb_iq_demod;
    localparam int ADC_W = 12;
    localparam int NP    = 16;
    localparam int N     = 64 * NP;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             meas_start = 1'b0;
    logic             abort = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             adc_valid = 1'b0;
    logic [31:0]      iq_x, iq_y;
    logic             iq_valid, busy;

    iq_demod #(.ADC_W(ADC_W), .NUM_PERIODS(NP)) dut (
        .clk(clk), .rst(rst), .meas_start(meas_start), .abort(abort),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .iq_x(iq_x), .iq_y(iq_y), .iq_valid(iq_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int pulses = 0;
    always @(posedge clk) if (iq_valid) pulses++;

    int total = 0;
    int bad   = 0;
    int cos_t[64];
    int sin_t[64];
    int smp[N];

    typedef struct {
        int     mode;
        int     gap;
        longint ex;
        longint ey;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic model(output longint ex, output longint ey);
        longint sx, sy;
        sx = 0;
        sy = 0;
        for (int i = 0; i < N; i++) begin
            sx += longint'(smp[i]) * cos_t[i % 64];
            sy += longint'(smp[i]) * sin_t[i % 64];
        end
        ex = sx >>> 6;
        ey = sy >>> 6;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       smp[i] = 500;
                1:       smp[i] = (i % 64 == 0) ? 1000 : 0;
                2:       smp[i] = (i % 64 == 16) ? -1000 : 0;
                3:       smp[i] = (i % 64 == 8) ? -2048 : 0;
                default: smp[i] = int'($urandom_range(0, 4095)) - 2048;
            endcase
        end
    endtask

    task automatic feed(input int i, input int gap, input int poke);
        if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
            adc_valid = 1'b0;
            adc_data  = ADC_W'($urandom);
            @(posedge clk); #1;
        end
        adc_data  = ADC_W'(smp[i]);
        adc_valid = 1'b1;
        if (poke != 0 && i == 500) meas_start = 1'b1;
        @(posedge clk); #1;
        meas_start = 1'b0;
        adc_valid  = 1'b0;
    endtask

    // Leaves the bench #1 after the edge that raised iq_valid (or after the bound expires).
    task automatic run_meas(input string name, input int gap, input int poke,
                            output longint gx, output longint gy, output int lat);
        meas_start = 1'b1;
        @(posedge clk); #1;
        meas_start = 1'b0;
        check({name, " busy"}, busy, 1);
        for (int i = 0; i < N; i++) feed(i, gap, poke);
        // Late samples must be ignored.
        adc_valid = 1'b1;
        adc_data  = 12'h7ff;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (iq_valid) break;
        end
        adc_valid = 1'b0;
        gx = longint'($signed(iq_x));
        gy = longint'($signed(iq_y));
    endtask

    task automatic full_run(input string name, input int gap, input int poke, input int b2b,
                            input longint ex, input longint ey);
        longint gx, gy;
        int     lat, p0;
        p0 = pulses;
        run_meas(name, gap, poke, gx, gy, lat);
        check({name, " latency"}, lat, 3);
        check({name, " iq_x"}, gx, ex);
        check({name, " iq_y"}, gy, ey);
        if (b2b != 0) meas_start = 1'b1;
        @(posedge clk); #1;
        meas_start = 1'b0;
        check({name, " pulses"}, pulses - p0, 1);
        check({name, " busy after"}, busy, b2b != 0 ? 1 : 0);
        if (b2b != 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            check({name, " abort b2b"}, busy, 0);
        end
    endtask

    vec_t vt[5];

    initial begin
        longint ex, ey, prev_x;
        int     p0;

        for (int i = 0; i < 64; i++) begin
            cos_t[i] = rnd(16383.0 * $cos(2.0 * 3.14159265358979 * i / 64.0));
            sin_t[i] = rnd(16383.0 * $sin(2.0 * 3.14159265358979 * i / 64.0));
        end

        vt[0] = '{mode: 0, gap: 0, ex: 0,        ey: 0};
        vt[1] = '{mode: 1, gap: 0, ex: 4095750,  ey: 0};
        vt[2] = '{mode: 2, gap: 0, ex: 0,        ey: -4095750};
        vt[3] = '{mode: 1, gap: 1, ex: 4095750,  ey: 0};
        vt[4] = '{mode: 3, gap: 2, ex: -5931520, ey: -5931520};

        #2;
        check("reset iq_x", iq_x, 0);
        check("reset iq_y", iq_y, 0);
        check("reset iq_valid", iq_valid, 0);
        check("reset busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fill(vt[v].mode);
            full_run($sformatf("vec%0d", v), vt[v].gap, 0, v == 1 ? 1 : 0, vt[v].ex, vt[v].ey);
        end

        for (int r = 0; r < 4; r++) begin
            fill(9);
            model(ex, ey);
            full_run($sformatf("rand%0d", r), 2, r == 1 ? 1 : 0, 0, ex, ey);
        end

        // Abort at sample 300 with a simultaneous meas_start.
        prev_x = longint'($signed(iq_x));
        p0 = pulses;
        fill(9);
        meas_start = 1'b1;
        @(posedge clk); #1;
        meas_start = 1'b0;
        for (int i = 0; i < 300; i++) feed(i, 2, 0);
        abort = 1'b1;
        meas_start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        meas_start = 1'b0;
        check("abort busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("abort no pulse", pulses - p0, 0);
        check("abort iq_x stable", longint'($signed(iq_x)), prev_x);
        fill(9);
        model(ex, ey);
        full_run("after abort", 0, 0, 0, ex, ey);

        // Asynchronous reset in the middle of accumulation.
        p0 = pulses;
        fill(9);
        meas_start = 1'b1;
        @(posedge clk); #1;
        meas_start = 1'b0;
        for (int i = 0; i < 200; i++) feed(i, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("mid rst iq_x", iq_x, 0);
        check("mid rst iq_y", iq_y, 0);
        check("mid rst busy", busy, 0);
        check("mid rst iq_valid", iq_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no stale pulse", pulses - p0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fill(9);
        model(ex, ey);
        full_run("after rst", 2, 0, 0, ex, ey);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
